imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-stream program loader: the write side of the instruction memory the processor fetches from.
- Receives a framed byte stream from a host link over a valid/ready handshake, assembles big-endian 32-bit words, and writes them to consecutive instruction-memory word addresses.
- Holds the processor in reset until a complete image with a correct checksum has been written.

Parameters:
ADDR_W, 10, instruction-memory word-address width (capacity 2^ADDR_W words = 1024)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  single-cycle pulse; begins a load (honoured only in IDLE, DONE, ERR)
byte_valid  input  1  host has a byte on byte_data
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction-memory write enable, one-cycle pulse per word
imem_waddr  output  ADDR_W  word address of the write
imem_wdata  output  32  word being written
cpu_rst  output  1  processor reset request; high = processor held
busy  output  1  load in progress
done  output  1  image loaded and checksum correct (level)
err  output  1  load failed (level, sticky until next start or rst)
word_count  output  16  number of words written in the current/last load

Behaviour:
- Frame format, in order:
  - LEN_HI byte, LEN_LO byte: N = 16-bit word count.
  - N words, 4 bytes each, most-significant byte first.
  - CHK byte: XOR of every preceding frame byte, length bytes included.
- Transfer rule: a byte is consumed on a rising edge where byte_valid && byte_ready. byte_data is ignored at all other times.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
- Reset (async) values:
  - state=IDLE; cpu_rst=1.
  - byte_ready, imem_we, busy, done, err = 0.
  - imem_waddr=0, imem_wdata=0, word_count=0.
  - Internal byte index, word index and checksum accumulator = 0.
- IDLE: byte_ready=0, cpu_rst=1.
- start in IDLE, DONE or ERR:
  - Next state LEN_HI.
  - Clear done, err, word_count, word index, byte index and checksum.
  - Drive cpu_rst=1.
- start in LEN_HI, LEN_LO, DATA or CHK: ignored.
- busy=1 and byte_ready=1 in LEN_HI, LEN_LO, DATA and CHK.
- LEN_HI -> LEN_LO on transfer; LEN_LO -> DATA on transfer.
- Length checks, applied at the LEN_LO transfer:
  - N == 0: go to CHK instead of DATA.
  - N > 2^ADDR_W: go to ERR.
- DATA word assembly:
  - Each transfer shifts the byte into a 32-bit shift register and increments the byte index modulo 4.
  - On the 4th byte's transfer edge the next-cycle registered outputs are: imem_we=1, imem_wdata=assembled word, imem_waddr=current word index.
  - The word index and word_count increment on that same edge.
  - Write latency is exactly one cycle after the completing byte's edge. imem_we is never high for two consecutive cycles unless a new word completes.
  - When the word just completed is the Nth, the next state is CHK.
- CHK: on transfer, compare the byte to the accumulator. Match -> DONE; mismatch -> ERR.
- DONE: done=1, busy=0, byte_ready=0, cpu_rst=0 from the first DONE cycle.
- ERR: err=1, busy=0, byte_ready=0, cpu_rst=1. Words already written stay written; there is no rollback.
- The checksum accumulator XORs every transferred byte, LEN_HI through the last data byte.
- Arithmetic widths:
  - Word index is ADDR_W+1 bits, so that N = 2^ADDR_W completes.
  - imem_waddr is its low ADDR_W bits; there is no wrap, because the length check prevents overflow.
- Back-pressure: byte_valid may drop at any time between bytes. Partially assembled words and the checksum hold their values.
- Asynchronous rst mid-load: all state returns to reset values immediately. No further imem_we pulses; the partial word is discarded.

Test Plan:
1. Reset then start; send 00 01 84 01 04 00 80 with byte_valid=1 continuously. Required: a single imem_we pulse one cycle after byte 0x00 at waddr 0 with wdata 0x84010400; then done=1, cpu_rst=0, word_count=1.
2. Start; send 00 02 00 00 00 01 12 34 56 78 0B with byte_valid toggling 1/0 every cycle. Required: writes (0, 0x00000001) and (1, 0x12345678); done=1, err=0.
3. Same frame as scenario 1 but checksum byte 0x81. Required: word 0 written, then err=1, done=0, cpu_rst stays 1; a new start clears err and a correct frame reaches DONE.
4. Length 04 01 (1025 > 1024). Required: ERR the cycle after the LEN_LO transfer, no imem_we pulses, byte_ready=0.
5. Length 00 00, checksum 00. Required: DONE with word_count=0 and no writes. Separately, a start pulse issued during DATA is ignored and the load completes normally.
6. Assert rst after 6 bytes of the scenario 2 frame. Required: immediately cpu_rst=1, busy=0, imem_we=0, word_count=0; then after start, a full scenario 2 frame writes both words correctly.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory program loader: takes a length-prefixed, XOR-checksummed byte stream,
// writes big-endian 32-bit words to consecutive addresses, and releases the CPU on success.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_len_hi;
    logic [15:0]       r_len;
    logic [23:0]       r_shift;
    logic [1:0]        r_byte_idx;
    logic [ADDR_W:0]   r_word_idx;
    logic [7:0]        r_chk;

    logic              w_xfer;
    logic              w_start_ok;
    logic [15:0]       w_len;
    logic [ADDR_W:0]   w_word_next;
    logic              w_last_byte;
    logic              w_last_word;

    assign w_xfer      = byte_valid && byte_ready;
    assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign w_len       = {r_len_hi, byte_data};
    assign w_word_next = r_word_idx + {{ADDR_W{1'b0}}, 1'b1};
    assign w_last_byte = (r_byte_idx == 2'd3);
    // Word index is one bit wider than the address so a full 2^ADDR_W image can finish.
    assign w_last_word = (17'(w_word_next) == {1'b0, r_len});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        cpu_rst    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (w_xfer) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (w_xfer) begin
                    if (w_len == 16'd0)
                        w_next = S_CHK;
                    else if ({1'b0, w_len} > (17'd1 << ADDR_W))
                        w_next = S_ERR;
                    else
                        w_next = S_DATA;
                end
            end
            S_DATA: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (w_xfer && w_last_byte && w_last_word) w_next = S_CHK;
            end
            S_CHK: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (w_xfer) w_next = (byte_data == r_chk) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
                if (start) w_next = S_LEN_HI;
            end
            S_ERR: begin
                err = 1'b1;
                if (start) w_next = S_LEN_HI;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            r_len_hi   <= '0;
            r_len      <= '0;
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_chk      <= '0;
        end else begin
            imem_we <= 1'b0;
            if (w_start_ok) begin
                word_count <= '0;
                r_len_hi   <= '0;
                r_len      <= '0;
                r_shift    <= '0;
                r_byte_idx <= '0;
                r_word_idx <= '0;
                r_chk      <= '0;
            end else if (w_xfer) begin
                case (r_state)
                    S_LEN_HI: begin
                        r_len_hi <= byte_data;
                        r_chk    <= r_chk ^ byte_data;
                    end
                    S_LEN_LO: begin
                        r_len <= w_len;
                        r_chk <= r_chk ^ byte_data;
                    end
                    S_DATA: begin
                        r_chk      <= r_chk ^ byte_data;
                        r_shift    <= {r_shift[15:0], byte_data};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (w_last_byte) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {r_shift, byte_data};
                            imem_waddr <= r_word_idx[ADDR_W-1:0];
                            r_word_idx <= w_word_next;
                            word_count <= word_count + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes go into a scoreboard queue that a
// negedge monitor drains whenever imem_we is seen; status outputs are checked inline.
module tb_imem_loader;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       word_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [ADDR_W+31:0] sb_q[$];
    logic [ADDR_W+31:0] mon_exp;
    logic [7:0]         frame[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                         imem_waddr, imem_wdata);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({imem_waddr, imem_wdata} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL write: got addr %0h data %0h, expected addr %0h data %0h",
                             imem_waddr, imem_wdata, mon_exp[ADDR_W+31:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_start();
        pulse_start();
        check("start_busy", busy, 1);
        check("start_ready", byte_ready, 1);
        check("start_cpu_rst", cpu_rst, 1);
        check("start_done", done, 0);
        check("start_err", err, 0);
        check("start_wcount", word_count, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit toggle, input bit completes);
        int n = 0;
        byte_data  = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (byte_ready !== 1'b1) begin
            check("ready_timeout", {31'd0, byte_ready}, 1);
        end else begin
            @(posedge clk); #1;
            if (completes) check("we_latency", imem_we, 1);
        end
        byte_valid = 1'b0;
        if (toggle) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input bit toggle, input int start_at);
        int                n;
        bit                comp;
        logic [31:0]       w;
        logic [ADDR_W-1:0] a;
        n = (frame.size() >= 2) ? int'({frame[0], frame[1]}) : 0;
        w = '0;
        for (int i = 0; i < frame.size(); i++) begin
            if (i == start_at) pulse_start();
            comp = 1'b0;
            if (i >= 2 && i < 2 + 4 * n) begin
                w = {w[23:0], frame[i]};
                if ((i - 2) % 4 == 3) begin
                    comp = 1'b1;
                    a    = ADDR_W'((i - 2) / 4);
                    sb_q.push_back({a, w});
                end
            end
            send_byte(frame[i], toggle, comp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #1;
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_ready", byte_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_waddr", imem_waddr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_wcount", word_count, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", byte_ready, 0);
        check("idle_cpu_rst", cpu_rst, 1);

        // Scenario 1: one word, continuous valid
        do_start();
        frame = '{8'h00, 8'h01, 8'h84, 8'h01, 8'h04, 8'h00, 8'h80};
        send_frame(1'b0, -1);
        check("s1_we_single", imem_we, 0);
        check("s1_done", done, 1);
        check("s1_cpu_rst", cpu_rst, 0);
        check("s1_busy", busy, 0);
        check("s1_wcount", word_count, 1);

        // Scenario 2: two words, valid toggling
        do_start();
        frame = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01,
                  8'h12, 8'h34, 8'h56, 8'h78, 8'h0B};
        send_frame(1'b1, -1);
        check("s2_done", done, 1);
        check("s2_err", err, 0);
        check("s2_wcount", word_count, 2);

        // Scenario 3: bad checksum, then recovery
        do_start();
        frame = '{8'h00, 8'h01, 8'h84, 8'h01, 8'h04, 8'h00, 8'h81};
        send_frame(1'b0, -1);
        check("s3_err", err, 1);
        check("s3_done", done, 0);
        check("s3_cpu_rst", cpu_rst, 1);
        check("s3_ready", byte_ready, 0);
        repeat (2) @(posedge clk);
        #1 check("s3_err_sticky", err, 1);
        do_start();
        frame = '{8'h00, 8'h01, 8'h84, 8'h01, 8'h04, 8'h00, 8'h80};
        send_frame(1'b0, -1);
        check("s3_recover_done", done, 1);

        // Scenario 4: oversize length
        do_start();
        frame = '{8'h04, 8'h01};
        send_frame(1'b0, -1);
        check("s4_err", err, 1);
        check("s4_ready", byte_ready, 0);
        check("s4_busy", busy, 0);
        check("s4_cpu_rst", cpu_rst, 1);
        repeat (3) @(posedge clk);
        #1;

        // Scenario 5: zero length, then start ignored mid-DATA
        do_start();
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(1'b0, -1);
        check("s5_done", done, 1);
        check("s5_wcount", word_count, 0);
        do_start();
        frame = '{8'h00, 8'h01, 8'h84, 8'h01, 8'h04, 8'h00, 8'h80};
        send_frame(1'b0, 4);
        check("s5_start_ignored_done", done, 1);
        check("s5_start_ignored_wcount", word_count, 1);

        // Scenario 6: async reset mid-load, then a clean reload
        do_start();
        frame = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01};
        send_frame(1'b0, -1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("s6_cpu_rst", cpu_rst, 1);
        check("s6_busy", busy, 0);
        check("s6_we", imem_we, 0);
        check("s6_wcount", word_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        do_start();
        frame = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01,
                  8'h12, 8'h34, 8'h56, 8'h78, 8'h0B};
        send_frame(1'b1, -1);
        check("s6_done", done, 1);
        check("s6_wcount", word_count, 2);

        repeat (5) @(posedge clk);
        #1 check("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
